uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx byte transmitter between NUM_REQ requesters (e.g. debug, status, log channels).

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter sharing one uart_tx among NUM_REQ channels
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              r_state, w_state_next;
    logic [PW-1:0]       r_ptr, w_ptr_next;
    logic [PW-1:0]       r_gidx, w_gidx_next;
    logic [NUM_REQ-1:0]  r_grant, w_grant_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic [TW-1:0]       r_timer, w_timer_next;
    logic [PW-1:0]       w_pick;
    logic [PW-1:0]       w_ptr_after;
    logic                w_found;
    logic                w_gvalid;
    logic                w_xfer;
    int                  w_idx;

    assign w_gvalid    = req_valid_i[r_gidx];
    assign w_xfer      = (r_state == S_GRANT) && w_gvalid && tx_ready_i;
    assign w_ptr_after = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state == S_GRANT);

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    // Next-state: grant on any request, release on last byte, burst limit or idle timeout.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_gidx_next  = r_gidx;
        w_grant_next = r_grant;
        w_cnt_next   = r_cnt;
        w_timer_next = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_GRANT;
                    w_gidx_next  = w_pick;
                    w_grant_next = NUM_REQ'(1) << w_pick;
                    w_cnt_next   = '0;
                    w_timer_next = '0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    w_cnt_next   = r_cnt + 1'b1;
                    w_timer_next = '0;
                    if (req_last_i[r_gidx] ||
                        (MAX_BURST != 0 && w_cnt_next == CW'(MAX_BURST))) begin
                        w_state_next = S_IDLE;
                        w_grant_next = '0;
                        w_ptr_next   = w_ptr_after;
                        w_cnt_next   = '0;
                    end
                end else if (!w_gvalid) begin
                    // A stalled uart_tx (valid high, ready low) holds the timer.
                    w_timer_next = r_timer + 1'b1;
                    if (IDLE_TIMEOUT != 0 && w_timer_next == TW'(IDLE_TIMEOUT)) begin
                        w_state_next = S_IDLE;
                        w_grant_next = '0;
                        w_ptr_next   = w_ptr_after;
                        w_cnt_next   = '0;
                        w_timer_next = '0;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and arbitration registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_gidx  <= w_gidx_next;
            r_grant <= w_grant_next;
            r_cnt   <= w_cnt_next;
            r_timer <= w_timer_next;
        end
    end

    // Combinational pass-through of the granted channel; everything quiet when idle.
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        if (r_state == S_GRANT) begin
            tx_valid_o          = w_gvalid;
            tx_data_o           = req_data_i[8*r_gidx +: 8];
            req_ready_o[r_gidx] = tx_ready_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic        clk;
    logic        r_rstn;
    logic [3:0]  r_valid;
    logic [31:0] r_data;
    logic [3:0]  r_last;
    logic        r_ready;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [3:0]  grant;
    logic        busy;

    int n_checks;
    int n_errors;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (r_rstn),
        .req_valid_i (r_valid),
        .req_data_i  (r_data),
        .req_last_i  (r_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (r_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        ready;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rdy;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } byte_t;

    vec_t  tbl[10];
    byte_t q[4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        r_rstn  = 1'b0;
        r_valid = '0;
        r_last  = '0;
        r_data  = '0;
        r_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r_rstn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eg[12];
        logic [7:0] ed[12];
        logic [3:0] hs;
        int         idx1;
        bit         pres0, pres3;
        bit [3:0]   pres;
        int         m_g, m_ptr, m_cnt, m_idle, left, cyc;
        bit         m_busy, found, m_hs;
        logic [3:0] exp_grant;

        n_checks = 0;
        n_errors = 0;

        // Reset state: requests pending while rst_n is low must not leak through.
        r_rstn  = 1'b0;
        r_valid = 4'b1111;
        r_data  = 32'h44332211;
        r_last  = 4'b1111;
        r_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset tx_valid", 32'(tx_valid), 32'h0);
        chk("reset tx_data", 32'(tx_data), 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h0);

        // T1 single message from ch2, then pointer check (ch3 beats ch2 after ch2's release).
        tbl[0] = '{4'b0100, 32'h00A10000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[1] = '{4'b0100, 32'h00A10000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hA1, 4'b0100};
        tbl[2] = '{4'b0100, 32'h00A20000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0100};
        tbl[3] = '{4'b0100, 32'h00A30000, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hA3, 4'b0100};
        tbl[4] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[5] = '{4'b1100, 32'h33B00000, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[6] = '{4'b1100, 32'h33B00000, 4'b1100, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h33, 4'b1000};
        tbl[7] = '{4'b0100, 32'h00B00000, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[8] = '{4'b0100, 32'h00B00000, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hB0, 4'b0100};
        tbl[9] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            r_valid = tbl[i].valid;
            r_data  = tbl[i].data;
            r_last  = tbl[i].last;
            r_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("t1[%0d] grant", i), 32'(grant), 32'(tbl[i].e_grant));
            chk($sformatf("t1[%0d] busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("t1[%0d] tx_valid", i), 32'(tx_valid), 32'(tbl[i].e_txv));
            chk($sformatf("t1[%0d] tx_data", i), 32'(tx_data), 32'(tbl[i].e_txd));
            chk($sformatf("t1[%0d] req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            next_cycle();
        end

        // T2 fairness: all channels always hold 1-byte messages.
        do_reset();
        r_valid = 4'b1111;
        r_data  = 32'h03020100;
        r_last  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2[%0d] gap", k), 32'(grant), 32'h0);
            next_cycle();
            @(negedge clk);
            chk($sformatf("t2[%0d] grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            chk($sformatf("t2[%0d] data", k), 32'(tx_data), 32'(k % 4));
            next_cycle();
        end

        // T3 burst limit: ch1 six bytes without last, ch3 pending one-byte message.
        do_reset();
        eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
        ed = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h33, 8'h00, 8'h15, 8'h16, 8'h00, 8'h00};
        idx1  = 0;
        pres3 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            r_valid[1]     = (idx1 < 6);
            r_data[15:8]   = 8'(8'h11 + idx1);
            r_last[1]      = 1'b0;
            r_valid[3]     = pres3;
            r_data[31:24]  = 8'h33;
            r_last[3]      = 1'b1;
            @(negedge clk);
            chk($sformatf("t3[%0d] grant", c), 32'(grant), 32'(eg[c]));
            if (eg[c] != 4'h0) chk($sformatf("t3[%0d] data", c), 32'(tx_data), 32'(ed[c]));
            hs = r_valid & req_ready;
            next_cycle();
            if (hs[1]) idx1++;
            if (hs[3]) pres3 = 1'b0;
        end

        // T4 idle timeout: ch0 sends one byte then goes quiet, ch2 pending.
        do_reset();
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4};
        pres0 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            r_valid[0]    = pres0;
            r_data[7:0]   = 8'hA0;
            r_last[0]     = 1'b0;
            r_valid[2]    = 1'b1;
            r_data[23:16] = 8'hC2;
            r_last[2]     = 1'b1;
            @(negedge clk);
            chk($sformatf("t4[%0d] grant", c), 32'(grant), 32'(eg[c]));
            if (c == 1) chk("t4 data", 32'(tx_data), 32'hA0);
            hs = r_valid & req_ready;
            next_cycle();
            if (hs[0]) pres0 = 1'b0;
        end

        // T5 uart_tx stall for 20 cycles: no timeout, byte held, then transferred.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            r_valid[1]   = (c <= 21);
            r_data[15:8] = 8'h55;
            r_last[1]    = 1'b1;
            r_ready      = (c == 21);
            @(negedge clk);
            if (c == 0 || c == 22) begin
                chk($sformatf("t5[%0d] grant", c), 32'(grant), 32'h0);
            end else begin
                chk($sformatf("t5[%0d] grant", c), 32'(grant), 32'h2);
                chk($sformatf("t5[%0d] tx_data", c), 32'(tx_data), 32'h55);
                chk($sformatf("t5[%0d] req_ready", c), 32'(req_ready), (c == 21) ? 32'h2 : 32'h0);
            end
            next_cycle();
        end

        // T6 reset mid-message: pointer sits at 3 when reset hits, so ch0 winning proves it cleared.
        do_reset();
        r_valid = 4'b0100; r_data = 32'h00220000; r_last = 4'b0100;
        @(negedge clk); next_cycle();
        @(negedge clk);
        chk("t6 ch2 grant", 32'(grant), 32'h4);
        next_cycle();
        r_valid = 4'b0010; r_data = 32'h00006100; r_last = 4'b0000;
        @(negedge clk); next_cycle();
        @(negedge clk);
        chk("t6 ch1 byte1", 32'(tx_data), 32'h61);
        next_cycle();
        r_data = 32'h00006200;
        r_rstn = 1'b0;
        @(negedge clk);
        chk("t6 pre-reset grant", 32'(grant), 32'h2);
        next_cycle();
        r_rstn  = 1'b1;
        r_valid = 4'b1001; r_data = 32'h3A00000A; r_last = 4'b1001;
        @(negedge clk);
        chk("t6 grant after reset", 32'(grant), 32'h0);
        chk("t6 tx_valid after reset", 32'(tx_valid), 32'h0);
        chk("t6 busy after reset", 32'(busy), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t6 ch0 wins", 32'(grant), 32'h1);
        chk("t6 ch0 data", 32'(tx_data), 32'h0A);
        next_cycle();

        // Randomized traffic against a message-level reference model.
        for (int ch = 0; ch < 4; ch++) begin
            q[ch].delete();
            for (int m = 0; m < 20; m++) begin
                int len;
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    byte_t e;
                    e.d = 8'($urandom);
                    e.l = (b == len - 1);
                    q[ch].push_back(e);
                end
            end
        end
        do_reset();
        pres = '0; m_busy = 1'b0; m_g = 0; m_ptr = 0; m_cnt = 0; m_idle = 0;
        left = 1; cyc = 0;
        while (cyc < 8000 && (left > 0 || m_busy)) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!pres[ch] && q[ch].size() > 0 && $urandom_range(0, 3) == 0) pres[ch] = 1'b1;
                r_valid[ch] = pres[ch];
                if (pres[ch]) begin
                    r_data[8*ch +: 8] = q[ch][0].d;
                    r_last[ch]        = q[ch][0].l;
                end else begin
                    r_data[8*ch +: 8] = 8'($urandom);
                    r_last[ch]        = 1'($urandom);
                end
            end
            r_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_grant = m_busy ? 4'(1 << m_g) : 4'h0;
            chk("rnd grant", 32'(grant), 32'(exp_grant));
            chk("rnd busy", 32'(busy), 32'(m_busy));
            chk("rnd tx_valid", 32'(tx_valid), m_busy ? 32'(r_valid[m_g]) : 32'h0);
            chk("rnd tx_data", 32'(tx_data), m_busy ? 32'(r_data[8*m_g +: 8]) : 32'h0);
            chk("rnd req_ready", 32'(req_ready), (m_busy && r_ready) ? 32'(exp_grant) : 32'h0);
            m_hs = m_busy && r_valid[m_g] && r_ready;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    if (!found && r_valid[(m_ptr + k) % NR]) begin
                        found  = 1'b1;
                        m_g    = (m_ptr + k) % NR;
                        m_busy = 1'b1;
                        m_cnt  = 0;
                        m_idle = 0;
                    end
                end
            end else if (m_hs) begin
                m_cnt++;
                m_idle = 0;
                if (r_last[m_g] || m_cnt == MAXB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_g + 1) % NR;
                end
            end else if (!r_valid[m_g]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_g + 1) % NR;
                end
            end
            next_cycle();
            if (m_hs) begin
                void'(q[m_g].pop_front());
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (!r_valid[ch] || !(m_hs && ch == m_g)) begin
                    pres[ch] = pres[ch];
                end else begin
                    pres[ch] = 1'b0;
                end
            end
            left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
            cyc++;
        end
        chk("rnd bytes left at end", 32'(left), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
